// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the fetch/decode/execute pipeline registers.
// Resolves load-use bubbles, taken-branch flushes and data-memory freezes, and
// provides debug halt/resume/single-step plus saturating stall/flush counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dec_rs1/rs2, dec_use_rs1/rs2  decode-stage source operands
//   ex_rd, ex_is_load             execute-stage destination / load flag
//   branch_taken, mem_busy        execute-stage branch result, memory wait
//   halt_req, resume, step        debug control
//   clear_cnt                     counter clear
//   pc_en .. de_flush             per-stage enables/flushes (same-cycle response)
//   halted, state                 controller state
//   stall_cnt, flush_cnt          performance counters
module pipeline_ctrl #(
    parameter int unsigned RWIDTH       = 5,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CWIDTH       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RWIDTH-1:0] dec_rs1,
    input  logic [RWIDTH-1:0] dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic [RWIDTH-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              step,
    input  logic              clear_cnt,
    output logic              pc_en,
    output logic              pc_sel_branch,
    output logic              fd_en,
    output logic              fd_flush,
    output logic              de_en,
    output logic              de_flush,
    output logic              halted,
    output logic [1:0]        state,
    output logic [CWIDTH-1:0] stall_cnt,
    output logic [CWIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    localparam int unsigned    FCW        = 3;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    state_t         state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           pend_q, pend_d;
    logic           hazard;
    logic           stall_ev;

    // Decode reads a register that the load in execute has not produced yet
    assign hazard = ex_is_load && (ex_rd != '0) &&
                    ((dec_use_rs1 && (ex_rd == dec_rs1)) ||
                     (dec_use_rs2 && (ex_rd == dec_rs2)));

    assign halted = (state_q == HALTED);
    assign state  = state_q;

    // Next-state and stage-control decode; mem_busy freezes everything including transitions
    always_comb begin
        pc_en         = 1'b0;
        pc_sel_branch = 1'b0;
        fd_en         = 1'b0;
        fd_flush      = 1'b0;
        de_en         = 1'b0;
        de_flush      = 1'b0;
        stall_ev      = 1'b0;
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        pend_d        = pend_q;
        if (!rst) begin
            case (state_q)
                RUN, STEP: begin
                    if (mem_busy) begin
                        stall_ev = 1'b1;
                    end else if (branch_taken) begin
                        pc_en         = 1'b1;
                        pc_sel_branch = 1'b1;
                        fd_en         = 1'b1;
                        fd_flush      = 1'b1;
                        de_en         = 1'b1;
                        de_flush      = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            fcnt_d  = FLUSH_LOAD;
                            // A step that branches must still end in HALTED after the flush
                            pend_d  = (state_q == STEP);
                        end else begin
                            state_d = (state_q == STEP) ? HALTED : RUN;
                        end
                    end else begin
                        if (hazard) begin
                            de_en    = 1'b1;
                            de_flush = 1'b1;
                            stall_ev = 1'b1;
                        end else begin
                            pc_en = 1'b1;
                            fd_en = 1'b1;
                            de_en = 1'b1;
                        end
                        if ((state_q == STEP) || halt_req) begin
                            state_d = HALTED;
                        end
                    end
                end
                FLUSH: begin
                    if (mem_busy) begin
                        stall_ev = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        fd_en    = 1'b1;
                        fd_flush = 1'b1;
                        de_en    = 1'b1;
                        de_flush = 1'b1;
                        fcnt_d   = fcnt_q - FCW'(1);
                        if (fcnt_q == FCW'(1)) begin
                            state_d = pend_q ? HALTED : RUN;
                            pend_d  = 1'b0;
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state_d = RUN;
                    end else if (step) begin
                        state_d = STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers and saturating counters; clear beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            fcnt_q    <= '0;
            pend_q    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
            if (clear_cnt) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (stall_ev && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + CWIDTH'(1);
                end
                if (fd_flush && (flush_cnt != '1)) begin
                    flush_cnt <= flush_cnt + CWIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (FLUSH_CYCLES=2, 4-bit counters so saturation is reachable).
module tb_pipeline_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned FC = 2;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [RW-1:0] dec_rs1, dec_rs2, ex_rd;
    logic          dec_use_rs1, dec_use_rs2, ex_is_load;
    logic          branch_taken, mem_busy, halt_req, resume, step, clear_cnt;
    logic          pc_en, pc_sel_branch, fd_en, fd_flush, de_en, de_flush, halted;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.RWIDTH(RW), .FLUSH_CYCLES(FC), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .halt_req(halt_req), .resume(resume), .step(step), .clear_cnt(clear_cnt),
        .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .fd_en(fd_en), .fd_flush(fd_flush),
        .de_en(de_en), .de_flush(de_flush), .halted(halted), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [RW-1:0] rd;
        logic          ld;
        logic          br;
        logic          mb;
        logic          hr;
        logic          res;
        logic          stp;
        logic          clr;
    } stim_t;

    typedef struct {
        logic [6:0]    ctl;
        logic [1:0]    st;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [1:0]    m_st;
    logic [2:0]    m_cnt;
    logic          m_pend;
    logic [CW-1:0] m_sc, m_fc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic hazard_of(input stim_t s);
        return s.ld && (s.rd != '0) && ((s.u1 && (s.rd == s.rs1)) || (s.u2 && (s.rd == s.rs2)));
    endfunction

    // Expected {pc_en, pc_sel_branch, fd_en, fd_flush, de_en, de_flush, halted}
    function automatic logic [6:0] model_ctl(input stim_t s);
        if (s.rst)        return {6'b000000, m_st == 2'd2};
        if (m_st == 2'd2) return 7'b0000001;
        if (s.mb)         return 7'b0000000;
        if (m_st == 2'd1) return 7'b1011110;
        if (s.br)         return 7'b1111110;
        if (hazard_of(s)) return 7'b0000110;
        return 7'b1010100;
    endfunction

    task automatic model_reset();
        m_st = 2'd0; m_cnt = 3'd0; m_pend = 1'b0; m_sc = '0; m_fc = '0;
    endtask

    task automatic model_step(input stim_t s);
        logic [6:0] c;
        logic       stall;
        c = model_ctl(s);
        if (s.rst) begin
            model_reset();
            return;
        end
        stall = (m_st != 2'd2) && (s.mb || (((m_st == 2'd0) || (m_st == 2'd3)) && !s.br && hazard_of(s)));
        if (s.clr) begin
            m_sc = '0;
            m_fc = '0;
        end else begin
            if (stall && (m_sc != '1)) m_sc = m_sc + CW'(1);
            if (c[3] && (m_fc != '1))  m_fc = m_fc + CW'(1);
        end
        if (!(s.mb && (m_st != 2'd2))) begin
            case (m_st)
                2'd0, 2'd3: begin
                    if (s.br) begin
                        if (FC > 1) begin
                            m_pend = (m_st == 2'd3);
                            m_cnt  = 3'(FC - 1);
                            m_st   = 2'd1;
                        end else begin
                            m_st = (m_st == 2'd3) ? 2'd2 : 2'd0;
                        end
                    end else if ((m_st == 2'd3) || s.hr) begin
                        m_st = 2'd2;
                    end
                end
                2'd1: begin
                    if (m_cnt == 3'd1) begin
                        m_st   = m_pend ? 2'd2 : 2'd0;
                        m_pend = 1'b0;
                    end
                    m_cnt = m_cnt - 3'd1;
                end
                default: begin
                    if (s.res)      m_st = 2'd0;
                    else if (s.stp) m_st = 2'd3;
                end
            endcase
        end
    endtask

    // One clock: drive at negedge, push expectation, sample before posedge, advance model
    task automatic cycle(input stim_t s);
        exp_t e;
        exp_t o;
        @(negedge clk);
        rst = s.rst; dec_rs1 = s.rs1; dec_rs2 = s.rs2; dec_use_rs1 = s.u1; dec_use_rs2 = s.u2;
        ex_rd = s.rd; ex_is_load = s.ld; branch_taken = s.br; mem_busy = s.mb;
        halt_req = s.hr; resume = s.res; step = s.stp; clear_cnt = s.clr;
        #1;
        e.ctl = model_ctl(s); e.st = m_st; e.sc = m_sc; e.fc = m_fc;
        sbq.push_back(e);
        #2;
        o = sbq.pop_front();
        check("ctl", 32'({pc_en, pc_sel_branch, fd_en, fd_flush, de_en, de_flush, halted}), 32'(o.ctl));
        check("state", 32'(state), 32'(o.st));
        check("stall_cnt", 32'(stall_cnt), 32'(o.sc));
        check("flush_cnt", 32'(flush_cnt), 32'(o.fc));
        @(posedge clk);
        model_step(s);
    endtask

    initial begin
        stim_t idle, s, b, hz;
        idle = '0;
        rst = 1'b1; dec_rs1 = '0; dec_rs2 = '0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
        ex_rd = '0; ex_is_load = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        halt_req = 1'b0; resume = 1'b0; step = 1'b0; clear_cnt = 1'b0;
        @(posedge clk);
        model_reset();

        s = idle; s.rst = 1'b1;
        cycle(s); cycle(s);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_flush", 32'(flush_cnt), 32'd0);

        // Load-use bubble, then a load to x0 which must not bubble
        hz = idle; hz.ld = 1'b1; hz.rd = 5'd5; hz.rs2 = 5'd5; hz.u2 = 1'b1;
        cycle(hz); cycle(idle);
        #1; check("lu_stall", 32'(stall_cnt), 32'd1);
        s = hz; s.rd = 5'd0; s.rs2 = 5'd0;
        cycle(s);
        #1; check("x0_stall", 32'(stall_cnt), 32'd1);

        // Taken branch: two flush cycles
        b = idle; b.br = 1'b1;
        cycle(b);
        #1; check("br_flush_state", 32'(state), 32'd1);
        cycle(idle);
        #1; check("br_run_state", 32'(state), 32'd0);
        check("br_flush_cnt", 32'(flush_cnt), 32'd2);

        // Freeze in the middle of FLUSH
        cycle(b);
        s = idle; s.mb = 1'b1;
        cycle(s); cycle(s); cycle(s);
        #1; check("frz_state", 32'(state), 32'd1);
        check("frz_stall", 32'(stall_cnt), 32'd4);
        cycle(idle);
        #1; check("frz_run", 32'(state), 32'd0);
        check("frz_flush", 32'(flush_cnt), 32'd4);

        // Branch and hazard together: branch only
        s = hz; s.br = 1'b1;
        cycle(s);
        #1; check("brhz_stall", 32'(stall_cnt), 32'd4);
        cycle(idle); cycle(idle);

        // mem_busy with branch: freeze, branch serviced when busy drops
        s = b; s.mb = 1'b1;
        cycle(s);
        #1; check("mbbr_state", 32'(state), 32'd0);
        check("mbbr_stall", 32'(stall_cnt), 32'd5);
        cycle(b);
        #1; check("mbbr_flush", 32'(state), 32'd1);
        cycle(idle);

        // Debug halt, held halt_req, single step
        s = idle; s.hr = 1'b1;
        cycle(s);
        #1; check("halt_state", 32'(state), 32'd2);
        cycle(s);
        #1; check("halt_hold", 32'(state), 32'd2);
        s = idle; s.stp = 1'b1;
        cycle(s);
        #1; check("step_state", 32'(state), 32'd3);
        cycle(idle);
        #1; check("step_back", 32'(state), 32'd2);

        // Step that takes a branch: FLUSH then HALTED
        cycle(s); cycle(b);
        #1; check("stepbr_flush", 32'(state), 32'd1);
        cycle(idle);
        #1; check("stepbr_halt", 32'(state), 32'd2);
        s = idle; s.stp = 1'b1; s.res = 1'b1;
        cycle(s);
        #1; check("res_wins", 32'(state), 32'd0);

        // Reset during FLUSH
        cycle(b);
        s = idle; s.rst = 1'b1;
        cycle(s);
        #1; check("rstfl_state", 32'(state), 32'd0);
        check("rstfl_stall", 32'(stall_cnt), 32'd0);
        check("rstfl_flush", 32'(flush_cnt), 32'd0);

        // Stall counter saturation, then clear beating increment
        for (int i = 0; i < 20; i++) cycle(hz);
        #1; check("sat_stall", 32'(stall_cnt), 32'd15);
        s = hz; s.clr = 1'b1;
        cycle(s);
        #1; check("clr_stall", 32'(stall_cnt), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            s.rst = ($urandom_range(99) == 0);
            s.rs1 = RW'($urandom_range(3));
            s.rs2 = RW'($urandom_range(3));
            s.rd  = RW'($urandom_range(3));
            s.u1  = 1'($urandom_range(1));
            s.u2  = 1'($urandom_range(1));
            s.ld  = 1'($urandom_range(1));
            s.br  = ($urandom_range(5) == 0);
            s.mb  = ($urandom_range(5) == 0);
            s.hr  = ($urandom_range(9) == 0);
            s.res = ($urandom_range(3) == 0);
            s.stp = ($urandom_range(3) == 0);
            s.clr = ($urandom_range(39) == 0);
            cycle(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
